// File: rtl/lectura_puntuacion_bcd_pkg.sv
// Shared game constants: score width, BCD digit count and the reader FSM encoding.
// Also reused by the score-storage block and the display controller.
package lectura_puntuacion_bcd_pkg;

    localparam int ANCHO_PUNTUACION = 13;
    localparam int NUM_DIGITOS      = 4;
    localparam int ANCHO_BCD        = NUM_DIGITOS * 4;
    localparam int ANCHO_REG        = ANCHO_BCD + ANCHO_PUNTUACION;
    localparam int ANCHO_CONT       = $clog2(ANCHO_PUNTUACION + 1);

    localparam logic [1:0] REPOSO   = 2'd0;
    localparam logic [1:0] DESPLAZA = 2'd1;
    localparam logic [1:0] FIN      = 2'd2;

    // Counter value seen on the edge that performs the final shift.
    localparam logic [ANCHO_CONT-1:0] ULTIMA_CUENTA = ANCHO_CONT'(ANCHO_PUNTUACION - 1);

    typedef logic [ANCHO_PUNTUACION-1:0] puntuacion_t;
    typedef logic [3:0]                  digito_bcd_t;

    typedef struct packed {
        digito_bcd_t millares;
        digito_bcd_t centenas;
        digito_bcd_t decenas;
        digito_bcd_t unidades;
    } bcd_t;

endpackage

// File: rtl/lectura_puntuacion_bcd_if.sv
// Request/result bundle between the display controller (master) and the BCD reader (slave).
interface lectura_puntuacion_bcd_if;
    import lectura_puntuacion_bcd_pkg::*;

    puntuacion_t puntuacionEntrada;
    logic        solicitud;
    logic        ocupado;
    logic        listo;
    digito_bcd_t unidades;
    digito_bcd_t decenas;
    digito_bcd_t centenas;
    digito_bcd_t millares;

    modport master (
        output puntuacionEntrada,
        output solicitud,
        input  ocupado,
        input  listo,
        input  unidades,
        input  decenas,
        input  centenas,
        input  millares
    );

    modport slave (
        input  puntuacionEntrada,
        input  solicitud,
        output ocupado,
        output listo,
        output unidades,
        output decenas,
        output centenas,
        output millares
    );

endinterface

// File: rtl/lectura_puntuacion_bcd_ajuste_bcd.sv
// Double-dabble correction for one BCD nibble: values of 5 or more get 3 added
// so that the following left shift carries correctly into the next decade.
module ajuste_bcd (
    input  logic [3:0] nibble_i,
    output logic [3:0] nibble_o
);

    assign nibble_o = (nibble_i >= 4'd5) ? (nibble_i + 4'd3) : nibble_i;

endmodule

// File: rtl/lectura_puntuacion_bcd.sv
// Sequential binary-to-BCD reader for the stored score: shift-and-add-3 over
// ANCHO_PUNTUACION cycles, result latched on the FIN edge with a one-cycle listo.
module lectura_puntuacion_bcd
    import lectura_puntuacion_bcd_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    lectura_puntuacion_bcd_if.slave  bus
);

    logic [1:0]            estado_q,    estado_d;
    logic [ANCHO_REG-1:0]  desplaza_q,  desplaza_d;
    logic [ANCHO_CONT-1:0] cuenta_q,    cuenta_d;
    bcd_t                  digitos_q,   digitos_d;
    logic                  listo_q,     listo_d;

    logic [ANCHO_REG-1:0]  ajustado;

    // Binary part passes through; each BCD nibble is corrected before the shift.
    assign ajustado[ANCHO_PUNTUACION-1:0] = desplaza_q[ANCHO_PUNTUACION-1:0];

    generate
        for (genvar gi = 0; gi < NUM_DIGITOS; gi++) begin : g_ajuste
            ajuste_bcd u_ajuste (
                .nibble_i (desplaza_q[ANCHO_PUNTUACION + 4*gi +: 4]),
                .nibble_o (ajustado[ANCHO_PUNTUACION + 4*gi +: 4])
            );
        end
    endgenerate

    always_comb begin
        estado_d   = estado_q;
        desplaza_d = desplaza_q;
        cuenta_d   = cuenta_q;
        digitos_d  = digitos_q;
        listo_d    = 1'b0;

        case (estado_q)
            REPOSO: begin
                if (bus.solicitud) begin
                    desplaza_d = {{ANCHO_BCD{1'b0}}, bus.puntuacionEntrada};
                    cuenta_d   = '0;
                    estado_d   = DESPLAZA;
                end
            end
            DESPLAZA: begin
                desplaza_d = {ajustado[ANCHO_REG-2:0], 1'b0};
                cuenta_d   = cuenta_q + 1'b1;
                if (cuenta_q == ULTIMA_CUENTA) begin
                    estado_d = FIN;
                end
            end
            FIN: begin
                digitos_d = bcd_t'(desplaza_q[ANCHO_REG-1:ANCHO_PUNTUACION]);
                listo_d   = 1'b1;
                estado_d  = REPOSO;
            end
            default: begin
                estado_d = REPOSO;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q   <= REPOSO;
            desplaza_q <= '0;
            cuenta_q   <= '0;
            digitos_q  <= '0;
            listo_q    <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            desplaza_q <= desplaza_d;
            cuenta_q   <= cuenta_d;
            digitos_q  <= digitos_d;
            listo_q    <= listo_d;
        end
    end

    assign bus.ocupado  = (estado_q != REPOSO);
    assign bus.listo    = listo_q;
    assign bus.unidades = digitos_q.unidades;
    assign bus.decenas  = digitos_q.decenas;
    assign bus.centenas = digitos_q.centenas;
    assign bus.millares = digitos_q.millares;

endmodule

// File: tb/tb_lectura_puntuacion_bcd.sv
// Directed bench for the BCD score reader: reset, extremes, back-to-back,
// ignored requests, mid-conversion reset and a table of hand-computed values.
module tb_lectura_puntuacion_bcd;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    lectura_puntuacion_bcd_if bus ();

    lectura_puntuacion_bcd dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic ciclo();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] digitos();
        return {bus.millares, bus.centenas, bus.decenas, bus.unidades};
    endfunction

    // Drives one request and waits for listo; checks busy span, latency, digits and pulse width.
    task automatic convertir(input string tag, input logic [12:0] valor, input logic [15:0] esp);
        int n;
        int altos;
        bus.puntuacionEntrada = valor;
        bus.solicitud         = 1'b1;
        ciclo();
        bus.solicitud = 1'b0;
        n     = 0;
        altos = 0;
        while (!bus.listo && n < 40) begin
            if (bus.ocupado) altos++;
            ciclo();
            n++;
        end
        chequear({tag, " latencia"}, n + 1, 15);
        chequear({tag, " ocupado"}, altos, 14);
        chequear({tag, " digitos"}, digitos(), esp);
        ciclo();
        chequear({tag, " listo_pulso"}, bus.listo, 1'b0);
        chequear({tag, " retiene"}, digitos(), esp);
    endtask

    typedef struct {
        logic [12:0] valor;
        logic [15:0] esp;
    } vector_t;

    vector_t tabla [10] = '{
        '{13'd5,    16'h0005},
        '{13'd59,   16'h0059},
        '{13'd99,   16'h0099},
        '{13'd100,  16'h0100},
        '{13'd999,  16'h0999},
        '{13'd1000, 16'h1000},
        '{13'd4095, 16'h4095},
        '{13'd5555, 16'h5555},
        '{13'd7080, 16'h7080},
        '{13'd8190, 16'h8190}
    };

    initial begin
        int n;
        int extra;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.solicitud         = 1'b0;
        bus.puntuacionEntrada = '0;
        ciclo();
        ciclo();
        reset = 1'b0;
        chequear("reset ocupado", bus.ocupado, 1'b0);
        chequear("reset listo", bus.listo, 1'b0);
        chequear("reset digitos", digitos(), 16'h0000);

        convertir("cero", 13'd0, 16'h0000);
        convertir("maximo", 13'd8191, 16'h8191);

        // Back-to-back with solicitud held; input change after E0 must not matter.
        bus.puntuacionEntrada = 13'd10;
        bus.solicitud         = 1'b1;
        ciclo();
        bus.puntuacionEntrada = 13'd20;
        n = 1;
        while (!bus.listo && n < 40) begin ciclo(); n++; end
        chequear("b2b primero latencia", n, 15);
        chequear("b2b primero digitos", digitos(), 16'h0010);
        n = 0;
        ciclo(); n++;
        while (!bus.listo && n < 40) begin ciclo(); n++; end
        bus.solicitud = 1'b0;
        chequear("b2b periodo", n, 15);
        chequear("b2b segundo digitos", digitos(), 16'h0020);
        ciclo();
        chequear("b2b sin tercero", bus.ocupado, 1'b0);

        // Request while busy is ignored; input change mid-conversion is ignored.
        bus.puntuacionEntrada = 13'd1234;
        bus.solicitud         = 1'b1;
        ciclo();
        bus.solicitud = 1'b0;
        n = 0;
        extra = 0;
        for (int e = 1; e <= 35; e++) begin
            if (e == 6) bus.puntuacionEntrada = 13'd8;
            if (e == 7) bus.solicitud = 1'b1;
            if (e == 8) bus.solicitud = 1'b0;
            ciclo();
            if (bus.listo) begin
                if (n == 0) n = e;
                else extra++;
            end
        end
        chequear("ignora latencia", n + 1, 15);
        chequear("ignora digitos", digitos(), 16'h1234);
        chequear("ignora listo_extra", extra, 0);

        // Reset at E6 of a conversion aborts it and clears the outputs.
        bus.puntuacionEntrada = 13'd8;
        bus.solicitud         = 1'b1;
        ciclo();
        bus.solicitud = 1'b0;
        for (int e = 1; e <= 5; e++) ciclo();
        reset = 1'b1;
        ciclo();
        reset = 1'b0;
        chequear("aborto ocupado", bus.ocupado, 1'b0);
        chequear("aborto listo", bus.listo, 1'b0);
        chequear("aborto digitos", digitos(), 16'h0000);
        ciclo();
        chequear("aborto sigue reposo", bus.ocupado, 1'b0);
        convertir("tras_reset", 13'd8, 16'h0008);

        foreach (tabla[i]) begin
            convertir($sformatf("tabla_%0d", tabla[i].valor), tabla[i].valor, tabla[i].esp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lectura_puntuacion_bcd.md
Name: lectura_puntuacion_bcd

Overview:
Reader side of the stored game score. It takes the 13-bit binary total score held by the score-storage block and, on request, converts it to four BCD digits for the 7-segment/score display path. Conversion is a sequential shift-and-add-3 (double dabble) engine with a request/done handshake, so the display controller reads a stable, latched result.

Parameters:
ANCHO_PUNTUACION, 13, width of the binary score input.
NUM_DIGITOS, 4, number of BCD output digits. Must satisfy 10^NUM_DIGITOS > 2^ANCHO_PUNTUACION.

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
puntuacionEntrada  input  13  binary score from storage block, sampled only on accepted request
solicitud  input  1  conversion request, level-sampled each edge
ocupado  output  1  high while a conversion is in progress
listo  output  1  one-cycle pulse: BCD outputs just updated
unidades  output  4  BCD ones digit
decenas  output  4  BCD tens digit
centenas  output  4  BCD hundreds digit
millares  output  4  BCD thousands digit

Behaviour:
- Reset (reset=1 at edge): state REPOSO, ocupado=0, listo=0, all digit outputs 0, shift register and counter 0. Reset wins over every other event, including mid-conversion; the partial result is discarded and outputs go to 0.
- FSM states: REPOSO, DESPLAZA, FIN. ocupado = (state != REPOSO), combinational from state.
- REPOSO: if solicitud=1 at edge E0, capture puntuacionEntrada into the binary part of the shift register, clear the BCD part, counter=0, go to DESPLAZA. Otherwise hold. Digit outputs hold their last values.
- DESPLAZA: each edge, for every BCD digit >= 5 add 3, then shift the whole {BCD, binary} register left by 1 and increment the counter. After ANCHO_PUNTUACION shifts (edges E1..E13), go to FIN.
- FIN: at edge E14, copy the BCD part to the digit outputs, set listo=1, go to REPOSO. listo clears at E15 unless a new conversion also ends there, which is impossible.
- Latency: request accepted at E0, outputs and listo valid after E14 (ANCHO_PUNTUACION+1 edges). ocupado is high from E0 through E14.
- solicitud while ocupado=1 is ignored, not queued. solicitud high in the listo cycle, state REPOSO, is accepted, so back-to-back conversions run every 15 cycles.
- puntuacionEntrada changes after E0 have no effect on the current conversion.
- Width rules: internal register NUM_DIGITOS*4 + ANCHO_PUNTUACION bits. The max input 8191 gives 8,1,9,1. No overflow is possible given the parameter constraint.
- Digit outputs change only at the FIN edge or on reset and are never transiently invalid.

Decomposition:
- Shared game package: state encoding (REPOSO/DESPLAZA/FIN), ANCHO_PUNTUACION=13 and NUM_DIGITOS=4 constants, reused by the score-storage block and display controller.
- Sub-module ajuste_bcd: combinational per-digit "if >= 5 add 3" on a 4-bit nibble. Instantiate NUM_DIGITOS times via generate.

Test Plan:
- Reset, then solicitud with puntuacionEntrada=0 -> ocupado high 14 cycles, listo pulse after E14, digits 0,0,0,0.
- puntuacionEntrada=8191 -> millares=8, centenas=1, decenas=9, unidades=1, listo exactly one cycle.
- Back-to-back: 10 then 20, solicitud held high continuously -> first listo gives 0,0,1,0; next listo 15 cycles later gives 0,0,2,0.
- Convert 1234; change input to 8 at E5 and pulse solicitud at E7 -> result 1,2,3,4; second request ignored (no extra listo).
- Convert 1234, then convert 8 with reset asserted at E6 -> ocupado=0, listo=0, digits 0 after reset; a fresh request with 8 -> 0,0,0,8.
- Randomised sweep 0..8191 against a reference model -> every digit matches; latency always 15 edges.
